// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-lookahead add/sub datapath between two requesters.
// The result, with optional signed saturation, is registered and tagged for its requester one cycle after acceptance.
module add_arbiter #(
  parameter int WIDTH    = 16,
  parameter bit RR_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req0_sat,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  input  logic             req1_sat,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovfl,
  output logic             rsp_cout
);

  localparam logic signed [WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [WIDTH-1:0] SAT_MIN = 16'sh8000;

  // Four 4-bit groups; group carries are fully looked ahead, carries inside a group ripple.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c;
    logic [3:0]       gg, gp;
    logic [4:0]       gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
            (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 1; i < 4; i++)
        c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
    end
    c[WIDTH] = gc[4];
    return {c[WIDTH], p ^ c[WIDTH-1:0]};
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] s,
                                                       input logic                    a_neg,
                                                       input logic                    clip);
    if (!clip) return s;
    return a_neg ? SAT_MIN : SAT_MAX;
  endfunction

  logic                    ptr;
  logic                    gnt0_p0, gnt1_p0, vld_p0;
  logic signed [WIDTH-1:0] a_p0, b_p0, beff_p0, s_p0, res_p0;
  logic                    sub_p0, sat_p0, cout_p0, ovfl_p0;

  // Stage p0: grant, operand select and shared adder (combinational)
  always_comb begin
    gnt0_p0 = rst_n & ~stall & req0_valid & (~req1_valid | ~ptr);
    gnt1_p0 = rst_n & ~stall & req1_valid & (~req0_valid | ptr);
    vld_p0  = gnt0_p0 | gnt1_p0;
    a_p0    = gnt1_p0 ? req1_a   : req0_a;
    b_p0    = gnt1_p0 ? req1_b   : req0_b;
    sub_p0  = gnt1_p0 ? req1_sub : req0_sub;
    sat_p0  = gnt1_p0 ? req1_sat : req0_sat;
    beff_p0 = sub_p0 ? ~b_p0 : b_p0;
    {cout_p0, s_p0} = cla_add(a_p0, beff_p0, sub_p0);
    ovfl_p0 = (a_p0[WIDTH-1] == beff_p0[WIDTH-1]) & (s_p0[WIDTH-1] != a_p0[WIDTH-1]);
    res_p0  = saturate(s_p0, a_p0[WIDTH-1], sat_p0 & ovfl_p0);
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;

  // Stage p1: response register; stall only gates grants, never this register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= RR_RESET;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_sum    <= '0;
      rsp_ovfl   <= 1'b0;
      rsp_cout   <= 1'b0;
    end else begin
      rsp0_valid <= gnt0_p0;
      rsp1_valid <= gnt1_p0;
      if (gnt0_p0)      ptr <= 1'b1;
      else if (gnt1_p0) ptr <= 1'b0;
      if (vld_p0) begin
        rsp_sum  <= res_p0;
        rsp_ovfl <= ovfl_p0;
        rsp_cout <= cout_p0;
      end
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: a reference model predicts grants and results,
// expected responses are queued on transfer and compared on the following cycle.
module tb_add_arbiter;

  localparam bit RR = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        req0_valid = 1'b0, req0_sub = 1'b0, req0_sat = 1'b0, req0_ready;
  logic [15:0] req0_a = '0, req0_b = '0;
  logic        req1_valid = 1'b0, req1_sub = 1'b0, req1_sat = 1'b0, req1_ready;
  logic [15:0] req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid, rsp_ovfl, rsp_cout;
  logic [15:0] rsp_sum;

  add_arbiter #(.WIDTH(16), .RR_RESET(RR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req0_sat(req0_sat), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .req1_sat(req1_sat), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_sum(rsp_sum),
    .rsp_ovfl(rsp_ovfl), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dest;
    logic [15:0] sum;
    logic        ovfl;
    logic        cout;
  } exp_t;

  exp_t q[$];
  exp_t last, mon_e;
  logic mptr;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_add(input logic d, input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, input logic sat);
    exp_t        e;
    int          sa, sb, r;
    logic [16:0] u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    u  = sub ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
    e.dest = d;
    e.ovfl = (r > 32767) || (r < -32768);
    e.cout = u[16];
    e.sum  = (sat && e.ovfl) ? ((r > 0) ? 16'h7FFF : 16'h8000) : u[15:0];
    return e;
  endfunction

  // Monitor: check last cycle's transfer, then predict this cycle's grants
  always @(negedge clk) begin
    logic er0, er1;
    if (!rst_n) begin
      q.delete();
      mptr = RR;
      last = '{dest: 1'b0, sum: 16'h0, ovfl: 1'b0, cout: 1'b0};
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_flags", {rsp_ovfl, rsp_cout}, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
    end else begin
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("rsp0_valid", rsp0_valid, mon_e.dest == 1'b0);
        chk("rsp1_valid", rsp1_valid, mon_e.dest == 1'b1);
        chk("rsp_sum", rsp_sum, mon_e.sum);
        chk("rsp_ovfl", rsp_ovfl, mon_e.ovfl);
        chk("rsp_cout", rsp_cout, mon_e.cout);
        last = mon_e;
      end else begin
        chk("idle_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("hold_sum", rsp_sum, last.sum);
        chk("hold_flags", {rsp_ovfl, rsp_cout}, {last.ovfl, last.cout});
      end
      er0 = !stall && req0_valid && (!req1_valid || mptr == 1'b0);
      er1 = !stall && req1_valid && (!req0_valid || mptr == 1'b1);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      if (er0) begin
        q.push_back(model_add(1'b0, req0_a, req0_b, req0_sub, req0_sat));
        mptr = 1'b1;
      end else if (er1) begin
        q.push_back(model_add(1'b1, req1_a, req1_b, req1_sub, req1_sat));
        mptr = 1'b0;
      end
    end
  end

  task automatic clear_inputs();
    stall = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0; req0_sat = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0; req1_sat = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic set_req(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sat);
    if (w == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub; req0_sat = sat;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub; req1_sat = sat;
    end
  endtask

  // Single directed operation with constant expectations for the response cycle
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic sat, input logic [15:0] esum, input logic eovf, input logic ecout);
    bit got = 0;
    @(posedge clk); #1;
    set_req(w, 1'b1, a, b, sub, sat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((w == 0) ? req0_ready : req1_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("op_timeout", 0, 1);
    @(posedge clk); #1;
    set_req(w, 1'b0, a, b, sub, sat);
    @(negedge clk);
    chk("dir_valid", (w == 0) ? rsp0_valid : rsp1_valid, 1);
    chk("dir_sum", rsp_sum, esum);
    chk("dir_ovfl", rsp_ovfl, eovf);
    chk("dir_cout", rsp_cout, ecout);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit x0, x1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    op(0, 16'h0003, 16'h0004, 0, 0, 16'h0007, 0, 0);
    op(1, 16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 1, 0);
    op(1, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 1, 0);
    op(1, 16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 1);
    op(0, 16'h0005, 16'h0005, 1, 0, 16'h0000, 0, 1);

    // Contention from reset: grants alternate starting at requester 0
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1, 16'h1000, 16'h0234, 0, 0);
    set_req(1, 1, 16'h0100, 16'h0001, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_r0", req0_ready, i % 2 == 0);
      chk("cont_r1", req1_ready, i % 2 == 1);
      chk("cont_rsp0", rsp0_valid, i % 2 == 1);
      chk("cont_rsp1", rsp1_valid, i > 0 && i % 2 == 0);
      if (i < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("cont_last", {rsp0_valid, rsp1_valid}, 2'b01);
    chk("cont_sum", rsp_sum, 16'h00FF);

    // Stall after one transfer: in-flight result still delivered, other side wins on release
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1, 16'h0010, 16'h0020, 0, 0);
    set_req(1, 1, 16'h0040, 16'h0002, 0, 0);
    @(negedge clk);
    chk("stall_first", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      chk("stall_rsp0", rsp0_valid, i == 0);
      if (i == 0) chk("stall_sum", rsp_sum, 16'h0030);
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    stall = 0;
    @(negedge clk);
    chk("release_r1", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (2) @(posedge clk);

    // Random traffic with stalls and withdrawals, checked entirely by the monitor
    x0 = 0; x1 = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!req0_valid || x0)
        set_req(0, $urandom_range(0, 3) != 0, rnd16(), rnd16(), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 9) == 0) req0_valid = 0;
      if (!req1_valid || x1)
        set_req(1, $urandom_range(0, 3) != 0, rnd16(), rnd16(), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 9) == 0) req1_valid = 0;
      stall = $urandom_range(0, 3) == 0;
      @(negedge clk);
      x0 = req0_valid && req0_ready;
      x1 = req1_valid && req1_ready;
    end
    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(posedge clk);

    // Reset between transfer and capture: no pulse, pointer back to RR_RESET
    op(0, 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);
    @(posedge clk); #1;
    set_req(0, 1, 16'h1234, 16'h1111, 0, 0);
    @(negedge clk);
    chk("mid_ready", req0_ready, 1);
    #2 rst_n = 0;
    req0_valid = 0;
    @(negedge clk);
    chk("mid_rsp", {rsp0_valid, rsp1_valid}, 0);
    chk("mid_sum", rsp_sum, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rsp", {rsp0_valid, rsp1_valid}, 0);
    @(posedge clk); #1;
    set_req(0, 1, 16'h0002, 16'h0003, 0, 0);
    set_req(1, 1, 16'h0004, 16'h0005, 0, 0);
    @(negedge clk);
    chk("post_ptr", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
